cla_pipe_adder16: RTL and testbench

Pipelined 16-bit adder built from four 4-bit carry-lookahead nibble stages, one nibble resolved per clock with the carry registered between stages. It sits downstream of the operand source and upstream of the result consumer. It sustains one addition per cycle at a fixed 4-cycle latency with valid/ready flow control. It replaces a single-cycle 16-bit ripple of CLA slices where the carry chain limits timing.

---
 rtl/cla_pipe_adder16.sv | 127 ++++++++++++
 tb/tb_cla_pipe_adder16.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder16.sv
// Pipelined adder: one 4-bit carry-lookahead nibble resolved per stage, carry registered between stages.
// Optional feature macro: CLA_PIPE_OVERFLOW_EN builds the signed-overflow flag; otherwise overflow is tied low.
module cla_pipe_adder16 #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W = 4 * NIBBLES;
  localparam int L = NIBBLES - 1;

  logic [NIBBLES-1:0] r_vld;
  logic [NIBBLES-1:0] r_cy;
  logic [W-1:0]       r_a   [NIBBLES];
  logic [W-1:0]       r_b   [NIBBLES];
  logic [W-1:0]       r_sum [NIBBLES];

  logic [NIBBLES-1:0] w_src_vld;
  logic [NIBBLES-1:0] w_src_cy;
  logic [W-1:0]       w_src_a   [NIBBLES];
  logic [W-1:0]       w_src_b   [NIBBLES];
  logic [W-1:0]       w_src_sum [NIBBLES];
  logic [W-1:0]       w_nxt_sum [NIBBLES];
  logic [5:0]         w_nib     [NIBBLES];
  logic               w_adv;

  // Returns {carry into bit 3, carry out of bit 3, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  // A single global advance keeps every token in lockstep, so bubbles collapse only when S4 is free.
  assign w_adv     = !r_vld[L] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[L];
  assign sum       = r_sum[L];
  assign cout      = r_cy[L];

  always_comb begin
    w_src_vld = '0;
    w_src_cy  = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      w_src_a[k]   = '0;
      w_src_b[k]   = '0;
      w_src_sum[k] = '0;
      w_nxt_sum[k] = '0;
      w_nib[k]     = '0;
    end

    w_src_vld[0] = in_valid;
    w_src_cy[0]  = cin;
    w_src_a[0]   = a;
    w_src_b[0]   = b;
    for (int k = 1; k < NIBBLES; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_cy[k]  = r_cy[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_sum[k] = r_sum[k-1];
    end

    for (int k = 0; k < NIBBLES; k++) begin
      w_nib[k]     = cla4(w_src_a[k][4*k +: 4], w_src_b[k][4*k +: 4], w_src_cy[k]);
      w_nxt_sum[k] = w_src_sum[k];
      w_nxt_sum[k][4*k +: 4] = w_nib[k][3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int k = 0; k < NIBBLES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_src_vld;
      for (int k = 0; k < NIBBLES; k++) begin
        r_cy[k]  <= w_nib[k][4];
        r_a[k]   <= w_src_a[k];
        r_b[k]   <= w_src_b[k];
        r_sum[k] <= w_nxt_sum[k];
      end
    end
  end

`ifdef CLA_PIPE_OVERFLOW_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_nib[L][5] ^ w_nib[L][4];
    end
  end

  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// Self-checking bench for cla_pipe_adder16 against an integer-arithmetic reference model.
module tb_cla_pipe_adder16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          acc_cyc[$];
  int          ret_cyc[$];

`ifdef CLA_PIPE_OVERFLOW_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  cla_pipe_adder16 #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int   u;
    int   s;
    logic v;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    v = OV && ((s > 32767) || (s < -32768));
    return {v, u[16:0]};
  endfunction

  // Called at a falling edge; records accepted operands and retired results, then advances one cycle.
  task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic ordy, output logic acc);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(model(x, y, c));
      acc_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_q.push_back({overflow, cout, sum});
      ret_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    logic acc;
    int   k;
    k = 0;
    while (got_q.size() < exp_q.size() && k < max_cyc) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      k++;
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    ret_cyc.delete();
  endtask

  task automatic test_reset();
    logic acc;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'($urandom()) | 16'h0101, 16'($urandom()), 1'b1, 1'b1, acc);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_out_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL midreset_sum got=%h exp=0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL midreset_cout got=%b exp=0", cout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL reset_stale_results got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_single();
    logic acc;
    clear_q();
    cycle(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, acc);
    for (int e = 1; e <= 3; e++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid edge=%0d got=%b exp=0", e, out_valid); end
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_cmp++; if (sum !== 16'h0002) begin n_bad++; $display("FAIL single_sum got=%h exp=0002", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL single_cout got=%b exp=0", cout); end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    n_cmp++;
    if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    else if (ret_cyc[0] - acc_cyc[0] !== 4) begin
      n_bad++; $display("FAIL single_latency got=%0d exp=4", ret_cyc[0] - acc_cyc[0]);
    end
  endtask

  task automatic test_carry();
    logic [15:0] ta[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [15:0] tb[3] = '{16'h0000, 16'hFFFF, 16'hFFFF};
    logic        tc[3] = '{1'b1, 1'b0, 1'b1};
    logic [17:0] te[3] = '{{1'b0, 1'b1, 16'h0000}, {1'b0, 1'b1, 16'hFFFE}, {1'b0, 1'b1, 16'hFFFF}};
    logic        acc;
    clear_q();
    for (int i = 0; i < 3; i++) cycle(1'b1, ta[i], tb[i], tc[i], 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL carry_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== te[i]) begin n_bad++; $display("FAIL carry_result idx=%0d got=%h exp=%h", i, got_q[i], te[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    clear_q();
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() !== 16) begin n_bad++; $display("FAIL b2b_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      n_cmp++; if (ret_cyc[i] - acc_cyc[0] !== 4 + i) begin
        n_bad++; $display("FAIL b2b_timing idx=%0d got=%0d exp=%0d", i, ret_cyc[i] - acc_cyc[0], 4 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] opa[10];
    logic [15:0] opb[10];
    logic        opc[10];
    logic        acc;
    logic        ordy;
    int          i;
    int          idx;
    clear_q();
    for (int k = 0; k < 10; k++) begin
      opa[k] = 16'($urandom());
      opb[k] = 16'($urandom());
      opc[k] = 1'($urandom_range(0, 1));
    end
    i = 0;
    for (int t = 0; t < 60 && got_q.size() < 10; t++) begin
      ordy = !(t >= 5 && t < 8);
      if (!ordy) begin
        out_ready = 1'b0;
        #1;
        idx = got_q.size();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready t=%0d got=%b exp=0", t, in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid t=%0d got=%b exp=1", t, out_valid); end
        n_cmp++;
        if (idx >= exp_q.size()) begin n_bad++; $display("FAIL bp_hold t=%0d got=none exp=pending result", t); end
        else if ({overflow, cout, sum} !== exp_q[idx]) begin
          n_bad++; $display("FAIL bp_hold t=%0d got=%h exp=%h", t, {overflow, cout, sum}, exp_q[idx]);
        end
      end
      if (i < 10) cycle(1'b1, opa[i], opb[i], opc[i], ordy, acc);
      else        cycle(1'b0, 16'h0, 16'h0, 1'b0, ordy, acc);
      if (acc) i++;
    end
    n_cmp++; if (got_q.size() !== 10) begin n_bad++; $display("FAIL bp_count got=%0d exp=10", got_q.size()); end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== model(opa[k], opb[k], opc[k])) begin
        n_bad++; $display("FAIL bp_result idx=%0d got=%h exp=%h", k, got_q[k], model(opa[k], opb[k], opc[k]));
      end
    end
  endtask

  task automatic test_fill();
    logic [15:0] xa;
    logic [15:0] xb;
    logic        xc;
    logic        acc;
    int          n_acc;
    clear_q();
    n_acc = 0;
    xa = 16'($urandom());
    xb = 16'($urandom());
    xc = 1'($urandom_range(0, 1));
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1, xa, xb, xc, 1'b0, acc);
      if (acc) begin
        n_acc++;
        xa = 16'($urandom());
        xb = 16'($urandom());
        xc = 1'($urandom_range(0, 1));
      end
    end
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL fill_accepts got=%0d exp=4", n_acc); end
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    drain(20);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL fill_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL fill_result idx=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ta[4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] tb[4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0001};
    logic [17:0] te[4];
    logic        acc;
    te[0] = {OV,   1'b0, 16'h8000};
    te[1] = {OV,   1'b1, 16'h0000};
    te[2] = {OV,   1'b1, 16'h7FFF};
    te[3] = {1'b0, 1'b1, 16'h0000};
    clear_q();
    for (int i = 0; i < 4; i++) cycle(1'b1, ta[i], tb[i], 1'b0, 1'b1, acc);
    drain(20);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL ovf_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== te[i]) begin n_bad++; $display("FAIL ovf_result idx=%0d got=%h exp=%h", i, got_q[i], te[i]); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_fill();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
